// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word and register-select widths plus the
// data-memory access FSM encoding used by the MEM stage.
package cpu_types_pkg;

    localparam int WORD_W   = 32;
    localparam int REGSEL_W = 5;

    typedef logic [WORD_W-1:0]   word_t;
    typedef logic [REGSEL_W-1:0] regbits_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } memfsm_t;

endpackage

// File: rtl/pipeline_dmem_ctrl.sv
// Data-memory request sequencer for the MEM stage: drives dREN/dWEN, holds a
// completed load while writeback is blocked, and raises the memory stall.
module pipeline_dmem_ctrl
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en_mw,
    input  logic              dREN_mem,
    input  logic              dWEN_mem,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dmemload,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic              mem_stall,
    output logic [WORD_W-1:0] load_data,
    output logic [CNT_W-1:0]  memwait_cnt
);

    memfsm_t           state_q, state_d;
    logic [WORD_W-1:0] lbuf_q, lbuf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              memop;
    logic              req_active;

    assign memop = dREN_mem | dWEN_mem;

    // Gating with nRST drops the request the moment reset is applied,
    // even while the access is still outstanding.
    assign req_active = nRST & (state_q != DONE);

    assign dmemREN   = req_active & dREN_mem;
    assign dmemWEN   = req_active & dWEN_mem;
    assign mem_stall = req_active & memop & ~dhit;
    assign load_data = (state_q == DONE) ? lbuf_q : dmemload;

    always_comb begin
        state_d = state_q;
        lbuf_d  = lbuf_q;
        unique case (state_q)
            IDLE: begin
                if (memop && dhit && !en_mw) begin
                    lbuf_d  = dmemload;
                    state_d = DONE;
                end else if (memop && !dhit) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (dhit) begin
                    lbuf_d  = dmemload;
                    state_d = en_mw ? IDLE : DONE;
                end
            end
            DONE: begin
                if (en_mw) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (mem_stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            lbuf_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lbuf_q  <= lbuf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign memwait_cnt = cnt_q;

endmodule

// File: rtl/pipeline_memory_writeback.sv
// MEM stage plus MEM/WB pipeline register: runs the data-memory handshake,
// selects the writeback value and latches it for the register file.
module pipeline_memory_writeback
    import cpu_types_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int REGSEL_W = 5,
    parameter int CNT_W    = 32
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                en_mw,
    input  logic                flush_mw,
    input  logic                dREN_mem,
    input  logic                dWEN_mem,
    input  logic                MemToReg_mem,
    input  logic                link_mem,
    input  logic                lui_mem,
    input  logic                RegWrite_mem,
    input  logic                halt_mem,
    input  logic [WORD_W-1:0]   port_o_mem,
    input  logic [WORD_W-1:0]   rdat2_mem,
    input  logic [WORD_W-1:0]   pc4_mem,
    input  logic [WORD_W-1:0]   luiimm_mem,
    input  logic [REGSEL_W-1:0] regWSEL_mem,
    output logic                dmemREN,
    output logic                dmemWEN,
    output logic [WORD_W-1:0]   dmemaddr,
    output logic [WORD_W-1:0]   dmemstore,
    input  logic [WORD_W-1:0]   dmemload,
    input  logic                dhit,
    output logic                mem_stall,
    output logic [WORD_W-1:0]   wdat_wb,
    output logic [REGSEL_W-1:0] regWSEL_wb,
    output logic                RegWrite_wb,
    output logic                halt_wb,
    output logic [CNT_W-1:0]    memwait_cnt
);

    logic [WORD_W-1:0]   load_data;
    logic [WORD_W-1:0]   wdat_d;
    logic [WORD_W-1:0]   wdat_q;
    logic [REGSEL_W-1:0] regWSEL_q;
    logic                RegWrite_q;
    logic                halt_q;

    assign dmemaddr  = port_o_mem;
    assign dmemstore = rdat2_mem;

    pipeline_dmem_ctrl #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_dmem_ctrl (
        .CLK         (CLK),
        .nRST        (nRST),
        .en_mw       (en_mw),
        .dREN_mem    (dREN_mem),
        .dWEN_mem    (dWEN_mem),
        .dhit        (dhit),
        .dmemload    (dmemload),
        .dmemREN     (dmemREN),
        .dmemWEN     (dmemWEN),
        .mem_stall   (mem_stall),
        .load_data   (load_data),
        .memwait_cnt (memwait_cnt)
    );

    always_comb begin
        wdat_d = port_o_mem;
        if (MemToReg_mem) begin
            wdat_d = load_data;
        end else if (link_mem) begin
            wdat_d = pc4_mem;
        end else if (lui_mem) begin
            wdat_d = luiimm_mem;
        end
    end

    // A stalled cycle with the register enabled emits a bubble: write enable
    // drops while data/select hold, so the register file sees no write.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wdat_q     <= '0;
            regWSEL_q  <= '0;
            RegWrite_q <= 1'b0;
            halt_q     <= 1'b0;
        end else if (flush_mw) begin
            wdat_q     <= '0;
            regWSEL_q  <= '0;
            RegWrite_q <= 1'b0;
        end else if (en_mw && !mem_stall) begin
            wdat_q     <= wdat_d;
            regWSEL_q  <= regWSEL_mem;
            RegWrite_q <= RegWrite_mem;
            if (halt_mem) begin
                halt_q <= 1'b1;
            end
        end else if (en_mw) begin
            RegWrite_q <= 1'b0;
        end
    end

    assign wdat_wb     = wdat_q;
    assign regWSEL_wb  = regWSEL_q;
    assign RegWrite_wb = RegWrite_q;
    assign halt_wb     = halt_q;

endmodule

// File: tb/tb_pipeline_memory_writeback.sv
// Scoreboard bench: instructions are modelled as sequential program steps over
// a word memory; a memory responder with random latency plays the data cache.
module tb_pipeline_memory_writeback;

    logic        CLK;
    logic        nRST;
    logic        en_mw, flush_mw;
    logic        dREN_mem, dWEN_mem, MemToReg_mem, link_mem, lui_mem;
    logic        RegWrite_mem, halt_mem;
    logic [31:0] port_o_mem, rdat2_mem, pc4_mem, luiimm_mem;
    logic [4:0]  regWSEL_mem;
    logic        dmemREN, dmemWEN;
    logic [31:0] dmemaddr, dmemstore, dmemload;
    logic        dhit;
    logic        mem_stall;
    logic [31:0] wdat_wb;
    logic [4:0]  regWSEL_wb;
    logic        RegWrite_wb, halt_wb;
    logic [31:0] memwait_cnt;

    pipeline_memory_writeback #(
        .WORD_W(32), .REGSEL_W(5), .CNT_W(32)
    ) dut (
        .CLK(CLK), .nRST(nRST), .en_mw(en_mw), .flush_mw(flush_mw),
        .dREN_mem(dREN_mem), .dWEN_mem(dWEN_mem), .MemToReg_mem(MemToReg_mem),
        .link_mem(link_mem), .lui_mem(lui_mem), .RegWrite_mem(RegWrite_mem),
        .halt_mem(halt_mem), .port_o_mem(port_o_mem), .rdat2_mem(rdat2_mem),
        .pc4_mem(pc4_mem), .luiimm_mem(luiimm_mem), .regWSEL_mem(regWSEL_mem),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .dmemload(dmemload), .dhit(dhit),
        .mem_stall(mem_stall), .wdat_wb(wdat_wb), .regWSEL_wb(regWSEL_wb),
        .RegWrite_wb(RegWrite_wb), .halt_wb(halt_wb), .memwait_cnt(memwait_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          nchecks = 0;
    int          nerrs   = 0;
    logic [31:0] ref_mem  [256];
    logic [31:0] resp_mem [256];
    logic [37:0] exp_q [$];
    int          force_lat = -1;
    int          hits = 0;
    int          memops = 0;
    int          stall_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: picks a latency per access, then returns/commits data.
    initial begin
        int lat;
        int cnt;
        bit busy;
        busy = 0; lat = 0; cnt = 0;
        dhit = 1'b0;
        dmemload = '0;
        forever begin
            @(posedge CLK); #1;
            if (dhit) begin
                dhit = 1'b0;
                busy = 0;
            end
            @(negedge CLK);
            if (dmemREN || dmemWEN) begin
                if (!busy) begin
                    busy = 1;
                    cnt  = 0;
                    lat  = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
                end
                if (cnt == lat) begin
                    dhit = 1'b1;
                    hits++;
                    if (dmemREN) dmemload = resp_mem[dmemaddr[9:2]];
                    if (dmemWEN) resp_mem[dmemaddr[9:2]] = dmemstore;
                end else begin
                    dmemload = $urandom;
                end
                cnt++;
            end else begin
                busy = 0;
            end
        end
    end

    // Monitor: samples the handshake before each edge, checks the result after.
    initial begin
        logic        cap, bub, req;
        logic [37:0] e;
        forever begin
            @(negedge CLK); #2;
            cap = nRST & en_mw & ~mem_stall & ~flush_mw;
            bub = nRST & en_mw & mem_stall & ~flush_mw;
            req = dmemREN | dmemWEN;
            if (!nRST) begin
                stall_seen = 0;
            end else begin
                if (mem_stall) stall_seen++;
                chk("stall_vs_req", {31'b0, mem_stall}, {31'b0, req & ~dhit});
                chk("req_kind", {30'b0, {dmemREN, dmemWEN} & ~{dREN_mem, dWEN_mem}}, 32'd0);
                if (req) begin
                    chk("dmemaddr", dmemaddr, port_o_mem);
                    chk("dmemstore", dmemstore, rdat2_mem);
                end
            end
            @(posedge CLK); #1;
            if (cap) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_capture", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_wdat", wdat_wb, e[31:0]);
                    chk("wb_sel", {27'b0, regWSEL_wb}, {27'b0, e[36:32]});
                    chk("wb_we", {31'b0, RegWrite_wb}, {31'b0, e[37]});
                end
            end
            if (bub) chk("bubble_we", {31'b0, RegWrite_wb}, 32'd0);
        end
    end

    task automatic idle_inputs();
        en_mw = 0; flush_mw = 0; dREN_mem = 0; dWEN_mem = 0; MemToReg_mem = 0;
        link_mem = 0; lui_mem = 0; RegWrite_mem = 0; halt_mem = 0;
        port_o_mem = 0; rdat2_mem = 0; pc4_mem = 0; luiimm_mem = 0; regWSEL_mem = 0;
    endtask

    // Issue one instruction into MEM and hold it until MEM/WB accepts it.
    task automatic issue(input logic ren, input logic wen, input logic m2r,
                         input logic lnk, input logic lu, input logic rw,
                         input logic hlt, input logic [31:0] alu,
                         input logic [31:0] st, input logic [31:0] pc,
                         input logic [31:0] li, input logic [4:0] sel,
                         input int en_off, output int cyc);
        logic [31:0] expv;
        logic [7:0]  idx;
        bit          acc;
        idx  = alu[9:2];
        expv = m2r ? ref_mem[idx] : lnk ? pc : lu ? li : alu;
        if (wen) ref_mem[idx] = st;
        if (ren || wen) memops++;
        exp_q.push_back({rw, sel, expv});
        dREN_mem = ren; dWEN_mem = wen; MemToReg_mem = m2r; link_mem = lnk;
        lui_mem = lu; RegWrite_mem = rw; halt_mem = hlt; port_o_mem = alu;
        rdat2_mem = st; pc4_mem = pc; luiimm_mem = li; regWSEL_mem = sel;
        cyc = 0;
        acc = 0;
        while (!acc) begin
            en_mw = (en_off < 0) ? ($urandom_range(0, 3) != 0) : (cyc >= en_off);
            @(negedge CLK); #2;
            acc = en_mw & ~mem_stall;
            @(posedge CLK); #1;
            cyc++;
            if (!acc && cyc > 60) begin
                $display("FAIL issue_timeout: got no acceptance expected within 60 cycles");
                $fatal(1, "issue timeout");
            end
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, s0, h0, kind;
        logic [31:0] m0, a, v;
        logic        lk, lu, rw;
        idle_inputs();
        nRST = 0;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            ref_mem[i] = v;
            resp_mem[i] = v;
        end
        ref_mem[8'h10]  = 32'hDEADBEEF;
        resp_mem[8'h10] = 32'hDEADBEEF;
        #3;
        chk("rst_wdat", wdat_wb, 32'd0);
        chk("rst_we", {31'b0, RegWrite_wb}, 32'd0);
        chk("rst_halt", {31'b0, halt_wb}, 32'd0);
        chk("rst_cnt", memwait_cnt, 32'd0);
        chk("rst_req", {30'b0, dmemREN, dmemWEN}, 32'd0);
        repeat (2) @(posedge CLK);
        #1 nRST = 1;

        // Zero-wait load hit.
        force_lat = 0; s0 = stall_seen;
        issue(1, 0, 1, 0, 0, 1, 0, 32'h40, 32'h0, 32'h0, 32'h0, 5'd3, 0, cyc);
        chk("hit0_cycles", cyc, 1);
        chk("hit0_nostall", stall_seen - s0, 0);
        chk("hit0_wdat", wdat_wb, 32'hDEADBEEF);
        chk("hit0_we", {31'b0, RegWrite_wb}, 32'd1);

        // Store with three wait cycles.
        force_lat = 3; s0 = stall_seen; m0 = memwait_cnt;
        issue(0, 1, 0, 0, 0, 0, 0, 32'h84, 32'h1234, 32'h0, 32'h0, 5'd0, 0, cyc);
        chk("st_cycles", cyc, 4);
        chk("st_stalls", stall_seen - s0, 3);
        chk("st_cnt", memwait_cnt - m0, 32'd3);

        // Load hit while MEM/WB is blocked for two cycles; reads the stored word.
        force_lat = 0; h0 = hits;
        issue(1, 0, 1, 0, 0, 1, 0, 32'h84, 32'h0, 32'h0, 32'h0, 5'd9, 2, cyc);
        chk("done_cycles", cyc, 3);
        chk("done_one_hit", hits - h0, 1);
        chk("done_wdat", wdat_wb, 32'h1234);

        // Writeback select priority.
        issue(0, 0, 0, 1, 0, 1, 0, 32'd5, 32'h0, 32'h104, 32'h00AB0000, 5'd1, 0, cyc);
        chk("pri_link", wdat_wb, 32'h104);
        issue(0, 0, 0, 0, 1, 1, 0, 32'd5, 32'h0, 32'h104, 32'h00AB0000, 5'd2, 0, cyc);
        chk("pri_lui", wdat_wb, 32'h00AB0000);
        issue(1, 0, 1, 1, 0, 1, 0, 32'd5, 32'h0, 32'h104, 32'h00AB0000, 5'd4, 0, cyc);
        chk("pri_m2r", wdat_wb, resp_mem[1]);
        issue(0, 0, 0, 0, 0, 1, 0, 32'd5, 32'h0, 32'h104, 32'h00AB0000, 5'd5, 0, cyc);
        chk("pri_alu", wdat_wb, 32'd5);

        // Halt is sticky through a flush; flush beats enable.
        issue(0, 0, 0, 0, 0, 1, 1, 32'h77, 32'h0, 32'h0, 32'h0, 5'd6, 0, cyc);
        chk("halt_set", {31'b0, halt_wb}, 32'd1);
        RegWrite_mem = 1; port_o_mem = 32'h99; regWSEL_mem = 5'd7;
        en_mw = 1; flush_mw = 1;
        @(posedge CLK); #1;
        idle_inputs();
        chk("flush_we", {31'b0, RegWrite_wb}, 32'd0);
        chk("flush_wdat", wdat_wb, 32'd0);
        chk("flush_halt", {31'b0, halt_wb}, 32'd1);

        // Reset while an access is outstanding.
        force_lat = 20;
        dREN_mem = 1; MemToReg_mem = 1; RegWrite_mem = 1; port_o_mem = 32'h80;
        regWSEL_mem = 5'd8; en_mw = 1;
        repeat (2) begin @(posedge CLK); #1; end
        chk("wait_stall", {31'b0, mem_stall}, 32'd1);
        #2 nRST = 0;
        #1;
        chk("arst_ren", {31'b0, dmemREN}, 32'd0);
        chk("arst_stall", {31'b0, mem_stall}, 32'd0);
        chk("arst_wb", {wdat_wb[25:0], regWSEL_wb, RegWrite_wb}, 32'd0);
        chk("arst_halt", {31'b0, halt_wb}, 32'd0);
        @(posedge CLK); #1;
        idle_inputs();
        force_lat = -1;
        nRST = 1;
        chk("arst_cnt", memwait_cnt, 32'd0);

        // Randomised instruction stream.
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 3);
            a  = {22'b0, 8'($urandom), 2'b0};
            lk = $urandom_range(0, 1);
            lu = $urandom_range(0, 1);
            rw = $urandom_range(0, 1);
            if (kind == 1)
                issue(1, 0, 1, lk, lu, 1, 0, a, $urandom, $urandom, $urandom, 5'($urandom), -1, cyc);
            else if (kind == 2)
                issue(0, 1, 0, 0, 0, 0, 0, a, $urandom, $urandom, $urandom, 5'($urandom), -1, cyc);
            else
                issue(0, 0, 0, lk, lu, rw, 0, $urandom, $urandom, $urandom, $urandom, 5'($urandom), -1, cyc);
        end

        repeat (2) @(posedge CLK);
        #1;
        chk("hit_count", hits, memops);
        chk("memwait_total", memwait_cnt, stall_seen);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule
